aes_word_loader: RTL
====================

# aes_word_loader

Word-serial front end for the AES-256 pipelined cipher. Packs 32-bit key and plaintext words into the 256-bit key and 128-bit block the cipher consumes, launches blocks into the cipher pipeline, and tracks in-flight blocks with a tag shift register. It captures the ciphertext exactly `LATENCY` cycles after launch. The cipher has no stall or enable, so this block is the only place that enforces key stability and result alignment.

## Interface
- `LATENCY`, 14, clock edges from the launch edge (cipher_datain load) to the ciphertext capture edge; ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_wr`  in  1  key word strobe.
- `key_word`  in  32  key word, most significant first (word 0 = bits [255:224]).
- `key_ready`  out  1  live key valid and no partial key pending.
- `key_err`  out  1  sticky: key word rejected (guard build only).
- `in_valid`  in  1  plaintext word valid.
- `in_ready`  out  1  plaintext word accepted when in_valid && in_ready.
- `in_word`  in  32  plaintext word, most significant first (word 0 = bits [127:96]).
- `cipher_datain`  out  128  registered block to the cipher.
- `cipher_key`  out  256  registered live key to the cipher.
- `cipher_dataout`  in  128  ciphertext from the cipher.
- `out_valid`  out  1  one-cycle pulse: out_block holds a new ciphertext.
- `out_block`  out  128  captured ciphertext.
- `busy`  out  1  at least one tag in flight.

## Operation
- **Key path.**
  - Each accepted key_wr shifts key_word into a 256-bit shadow register. A 3-bit key count advances 0..7.
  - On the 8th word, the count wraps to 0 and the shadow (including that word) is copied atomically to cipher_key. key_valid is then set.
  - key_ready = key_valid && key count == 0.
- **Block path.**
  - in_ready = key_ready.
  - Each accepted word shifts into a 128-bit assembly register. A 2-bit word count advances 0..3.
  - On the 4th word: the assembled block (including that word) is loaded into cipher_datain, and tag[0] is set at the same edge (launch).
- **Tags.**
  - A LATENCY-bit shift register; it shifts by one every edge.
  - An edge where tag[LATENCY-1] = 1 captures cipher_dataout into out_block and asserts out_valid for the following cycle.
  - busy = OR of all tags.
- Between launches, cipher_datain holds its value. The cipher output is ignored unless tagged.
- No backpressure on the output side: the consumer must accept every out_valid pulse.
- Maximum throughput is one block per 4 cycles.
- key_wr and an in_valid/in_ready handshake in the same cycle are both processed.
  - The launch uses the key live at that edge.
  - A key commit never coincides with a launch, because in_ready is low while the key count is nonzero.
- A partial plaintext block is retained across key loads.

## Timing
- **Reset values:**
  - cipher_key = 0, cipher_datain = 0, out_block = 0.
  - out_valid = 0, key_ready = 0, in_ready = 0, key_err = 0, busy = 0.
  - All counts and tags = 0; the shadow and assembly registers are cleared.
- **Latency:**
  - Block launched at edge T → out_valid high in the cycle after edge T+LATENCY.
  - With the default 14, this matches 13 registered rounds plus a combinational final round: datain register at T, round registers at T+1..T+13, capture at T+14.
- **Back-to-back launches** 4 cycles apart yield out_valid pulses 4 cycles apart, in order.
- **Key commit:** cipher_key changes on the edge accepting word 8. key_ready rises in the next cycle.
- **Reset mid-operation:** all tags are dropped and no out_valid follows. Partial key and partial block are discarded. A key reload is required.

## Configuration
- **`AES_LOADER_KEY_GUARD_EN` defined:**
  - key_wr while busy = 1 is dropped: the shadow and count are unchanged, and key_err is set sticky until rst.
  - This guarantees cipher_key is constant for every in-flight block.
- **`AES_LOADER_KEY_GUARD_EN` undefined:**
  - key_wr is always accepted and key_err is tied 0.
  - Software must drain (busy = 0) before rekeying; in-flight results are otherwise undefined.

## Test plan
- **FIPS-197 C.3 vector.**
  - Stimulus: key words 00010203 … 1c1d1e1f, then plaintext words 00112233 44556677 8899aabb ccddeeff.
  - Response: a single out_valid, 14 cycles after the launch edge, with out_block = 8ea2b7ca516745bfeafc49904b496089.
- **Streaming.**
  - Stimulus: 3 blocks with in_valid held high continuously.
  - Response: 3 out_valid pulses spaced 4 cycles apart, correct ciphertexts, busy falling 1 cycle after the last capture edge.
- **Rekey gating.**
  - Stimulus: after word 3 of a new key, drive in_valid.
  - Response: in_ready stays 0 until the cycle after word 8; the subsequent block encrypts under the new key.
- **Guard (macro defined).**
  - Stimulus: key_wr while a block is in flight.
  - Response: key_err = 1, cipher_key unchanged, in-flight ciphertext correct.
  - Same stimulus without the macro: the word is accepted and key_err stays 0.
- **Reset mid-flight.**
  - Stimulus: assert rst 5 cycles after a launch.
  - Response: no out_valid thereafter, key_ready = 0, all outputs at reset values.
- **Reset-state check.** With no key loaded, in_valid = 1 → in_ready = 0 and no launch occurs.

Source files
------------

// File: rtl/aes_word_loader.sv
// Word-serial key/plaintext packer and result aligner for a stall-free AES-256 pipeline.
// Optional key guard: define AES_LOADER_KEY_GUARD_EN to drop key writes while blocks are in flight.
module aes_word_loader #(
    parameter int unsigned LATENCY = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_wr,
    input  logic [31:0]  key_word,
    output logic         key_ready,
    output logic         key_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    output logic [127:0] cipher_datain,
    output logic [255:0] cipher_key,
    input  logic [127:0] cipher_dataout,
    output logic         out_valid,
    output logic [127:0] out_block,
    output logic         busy
);

    logic [255:0]         shadow;
    logic [2:0]           key_cnt;
    logic                 key_valid;
    logic [127:0]         asm_q;
    logic [1:0]           word_cnt;
    logic [LATENCY-1:0]   tags;
    logic                 key_accept;
    logic                 in_fire;
    logic                 launch;

    always_comb begin
        key_ready = key_valid && (key_cnt == 3'd0);
        in_ready  = key_ready;
        in_fire   = in_valid && in_ready;
        launch    = in_fire && (word_cnt == 2'd3);
        busy      = |tags;
`ifdef AES_LOADER_KEY_GUARD_EN
        key_accept = key_wr && !busy;
`else
        key_accept = key_wr;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow        <= '0;
            key_cnt       <= '0;
            key_valid     <= 1'b0;
            cipher_key    <= '0;
            asm_q         <= '0;
            word_cnt      <= '0;
            cipher_datain <= '0;
            tags          <= '0;
            out_valid     <= 1'b0;
            out_block     <= '0;
        end else begin
            if (key_accept) begin
                shadow  <= {shadow[223:0], key_word};
                key_cnt <= key_cnt + 3'd1;
                // The eighth word commits the whole key at once so the cipher never sees a mix.
                if (key_cnt == 3'd7) begin
                    cipher_key <= {shadow[223:0], key_word};
                    key_valid  <= 1'b1;
                end
            end
            if (in_fire) begin
                asm_q    <= {asm_q[95:0], in_word};
                word_cnt <= word_cnt + 2'd1;
                if (word_cnt == 2'd3)
                    cipher_datain <= {asm_q[95:0], in_word};
            end
            tags      <= {tags[LATENCY-2:0], launch};
            out_valid <= tags[LATENCY-1];
            if (tags[LATENCY-1])
                out_block <= cipher_dataout;
        end
    end

`ifdef AES_LOADER_KEY_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst)
            key_err <= 1'b0;
        else if (key_wr && busy)
            key_err <= 1'b1;
    end
`else
    always_comb key_err = 1'b0;
`endif

endmodule
